bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 110 +++++++++++
 tb/tb_bus_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one synchronous-RAM bus between a CPU and a DMA engine.
// DMA wins each cycle it requests, except that a long burst yields one cycle to the CPU.
module bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_AD,
  input  logic          cpu_RW,
  input  logic [DW-1:0] cpu_D_out,
  output logic [DW-1:0] cpu_D_in,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_AD,
  input  logic          dma_RW,
  input  logic [DW-1:0] dma_D_out,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_D_in,
  output logic [AW-1:0] mem_AD,
  output logic          mem_RW,
  output logic [DW-1:0] mem_D_out,
  input  logic [DW-1:0] mem_D_in
);

  localparam logic [7:0] C_BURST_LAST = 8'(MAX_BURST - 1);

  logic          w_dma_grant;
  logic [7:0]    r_burst_cnt;
  logic          r_force_cpu;
  logic          r_dma_rvalid;
  logic          r_last_cpu;
  logic [DW-1:0] r_cpu_hold;

  // Reset gates the grant directly so the CPU owns the bus while rst_n is low.
  assign w_dma_grant = rst_n & dma_req & ~r_force_cpu;

  // Burst counter and one-cycle CPU slot after MAX_BURST consecutive DMA grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= 8'd0;
      r_force_cpu <= 1'b0;
    end else if (w_dma_grant && (r_burst_cnt == C_BURST_LAST)) begin
      r_burst_cnt <= 8'd0;
      r_force_cpu <= 1'b1;
    end else if (w_dma_grant) begin
      r_burst_cnt <= r_burst_cnt + 8'd1;
      r_force_cpu <= 1'b0;
    end else begin
      r_burst_cnt <= 8'd0;
      r_force_cpu <= 1'b0;
    end
  end

  // Read-return tracking: the RAM answers one cycle after the address phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dma_rvalid <= 1'b0;
      r_last_cpu   <= 1'b1;
    end else begin
      r_dma_rvalid <= w_dma_grant & dma_RW;
      r_last_cpu   <= ~w_dma_grant;
    end
  end

  // CPU read data is captured so it survives while DMA cycles follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_hold <= '0;
    end else if (r_last_cpu) begin
      r_cpu_hold <= mem_D_in;
    end else begin
      r_cpu_hold <= r_cpu_hold;
    end
  end

  // Memory bus mux: exactly one owner drives every cycle, no idle turnaround.
  always_comb begin
    mem_AD    = cpu_AD;
    mem_RW    = cpu_RW;
    mem_D_out = cpu_D_out;
    if (w_dma_grant) begin
      mem_AD    = dma_AD;
      mem_RW    = dma_RW;
      mem_D_out = dma_D_out;
    end else begin
      mem_AD    = cpu_AD;
      mem_RW    = cpu_RW;
      mem_D_out = cpu_D_out;
    end
  end

  // Read-data return paths.
  always_comb begin
    cpu_D_in = r_cpu_hold;
    if (r_last_cpu) begin
      cpu_D_in = mem_D_in;
    end else begin
      cpu_D_in = r_cpu_hold;
    end
  end

  assign dma_D_in   = mem_D_in;
  assign dma_ack    = w_dma_grant;
  assign cpu_rdy    = ~w_dma_grant;
  assign dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter with a small synchronous RAM model and an
// expected-value queue popped at each sampling point.
module tb_bus_arbiter;

  localparam logic [7:0] C_CPU_D = 8'h3C;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_AD;
  logic        cpu_RW;
  logic [7:0]  cpu_D_out;
  logic [7:0]  cpu_D_in;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_AD;
  logic        dma_RW;
  logic [7:0]  dma_D_out;
  logic        dma_ack;
  logic        dma_rvalid;
  logic [7:0]  dma_D_in;
  logic [15:0] mem_AD;
  logic        mem_RW;
  logic [7:0]  mem_D_out;
  logic [7:0]  mem_D_in;

  logic [7:0]  ram [0:255];

  typedef struct {
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [15:0] dad;
    logic [7:0]  dd;
    logic [15:0] cad;
    logic        e_ack;
    logic        e_rdy;
    logic [15:0] e_mad;
    logic        e_mrw;
    logic [7:0]  e_md;
    logic        e_rv;
    logic        chk_cdin;
    logic [7:0]  e_cdin;
    logic        chk_ddin;
    logic [7:0]  e_ddin;
  } vec_t;

  vec_t tbl   [$];
  vec_t exp_q [$];
  int   n_vec;
  int   n_err;

  bus_arbiter #(.AW(16), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_AD(cpu_AD), .cpu_RW(cpu_RW), .cpu_D_out(cpu_D_out),
    .cpu_D_in(cpu_D_in), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_AD(dma_AD), .dma_RW(dma_RW), .dma_D_out(dma_D_out),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_D_in(dma_D_in),
    .mem_AD(mem_AD), .mem_RW(mem_RW), .mem_D_out(mem_D_out), .mem_D_in(mem_D_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    mem_D_in <= ram[mem_AD[7:0]];
    if (!mem_RW) ram[mem_AD[7:0]] <= mem_D_out;
  end

  // Expected bus owner follows the expected grant: DMA fields when acked, CPU fields otherwise.
  function automatic vec_t mk(input logic r, input logic q, input logic w,
                              input logic [15:0] da, input logic [7:0] dd,
                              input logic [15:0] ca, input logic ack, input logic rv,
                              input logic cc, input logic [7:0] cv,
                              input logic dc, input logic [7:0] dv);
    vec_t v;
    v.rst_n = r;  v.req = q;  v.rw = w;  v.dad = da;  v.dd = dd;  v.cad = ca;
    v.e_ack = ack;
    v.e_rdy = ~ack;
    v.e_mad = ack ? da : ca;
    v.e_mrw = ack ? w : 1'b1;
    v.e_md  = ack ? dd : C_CPU_D;
    v.e_rv  = rv;
    v.chk_cdin = cc;  v.e_cdin = cv;
    v.chk_ddin = dc;  v.e_ddin = dv;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic burst_ack [10];
    logic after_rst [6];
    logic prev;
    vec_t v;
    vec_t e;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[1] = 8'hA9;
    ram[3] = 8'h69;
    rst_n     = 1'b0;
    dma_req   = 1'b1;
    dma_AD    = 16'h0000;
    dma_RW    = 1'b1;
    dma_D_out = 8'h00;
    cpu_AD    = 16'h0000;
    cpu_RW    = 1'b1;
    cpu_D_out = C_CPU_D;

    // Reset with a pending request: CPU owns the bus.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0100, 8'h11, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0100, 8'h11, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    // Single DMA write, then back to CPU.
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0100, 8'h11, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0200, 8'hA5, 16'h0010, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0200, 8'hA5, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    // DMA read of RAM[1], data returned the next cycle.
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0001, 8'h00, 16'h0010, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0001, 8'h00, 16'h0010, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA9));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0001, 8'h00, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    // CPU read of 0x0003 followed by three DMA cycles; CPU data must persist.
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0005, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0005, 8'h00, 16'h0003, 1'b1, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0005, 8'h00, 16'h0003, 1'b1, 1'b1, 1'b1, 8'h69, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0005, 8'h00, 16'h0003, 1'b1, 1'b1, 1'b1, 8'h69, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0005, 8'h00, 16'h0003, 1'b0, 1'b1, 1'b1, 8'h69, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0005, 8'h00, 16'h0010, 1'b0, 1'b0, 1'b1, 8'h69, 1'b0, 8'h00));
    // Request held ten cycles: four grants, one forced CPU cycle, repeat.
    burst_ack = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0007, 8'h00, 16'h0010, burst_ack[i], prev, 1'b0, 8'h00, 1'b0, 8'h00));
      prev = burst_ack[i];
    end
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0007, 8'h00, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    // Reset mid-burst after two grants, then a full burst is available again.
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0009, 8'h00, 16'h0010, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0009, 8'h00, 16'h0010, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0009, 8'h00, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
    after_rst = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0009, 8'h00, 16'h0010, after_rst[i], prev, 1'b0, 8'h00, 1'b0, 8'h00));
      prev = after_rst[i];
    end
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0009, 8'h00, 16'h0010, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst_n     = v.rst_n;
      dma_req   = v.req;
      dma_RW    = v.rw;
      dma_AD    = v.dad;
      dma_D_out = v.dd;
      cpu_AD    = v.cad;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      chk("dma_ack",    i, {15'd0, dma_ack},    {15'd0, e.e_ack});
      chk("cpu_rdy",    i, {15'd0, cpu_rdy},    {15'd0, e.e_rdy});
      chk("mem_AD",     i, mem_AD,              e.e_mad);
      chk("mem_RW",     i, {15'd0, mem_RW},     {15'd0, e.e_mrw});
      chk("mem_D_out",  i, {8'd0, mem_D_out},   {8'd0, e.e_md});
      chk("dma_rvalid", i, {15'd0, dma_rvalid}, {15'd0, e.e_rv});
      if (e.chk_cdin) chk("cpu_D_in", i, {8'd0, cpu_D_in}, {8'd0, e.e_cdin});
      if (e.chk_ddin) chk("dma_D_in", i, {8'd0, dma_D_in}, {8'd0, e.e_ddin});
      @(posedge clk);
      #1;
    end
    if (ram[0] !== 8'hA5) begin
      n_err++;
      $display("FAIL ram_write: got %h expected %h", ram[0], 8'hA5);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
